sysarray_xfer_scheduler: RTL and testbench

Job sequencer between the kernel control interface and the AXI read/write master pair. Splits one host-requested transfer into fixed-size chunks, issues a start to both masters per chunk with per-chunk address/size, collects both completions, advances. Drives `ap_done`, `ap_idle` and `ap_ready` back to the control block. Bounds in-flight data per chunk so the systolic-array datapath can be re-armed between chunks.

---
 rtl/sysarray_xfer_scheduler.sv | 131 +++++++++++++
 tb/tb_sysarray_xfer_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysarray_xfer_scheduler.sv
// Splits one host transfer into C_CHUNK_BYTES chunks and sequences the AXI read/write masters per chunk.
// Latency: start pulses 1 cycle after ap_start, next chunk 1 cycle after both dones; optional SYSARRAY_SCHED_PERF_EN cycle counter.
// Backpressure: one chunk in flight; the next issue waits until both masters report done.
module sysarray_xfer_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_CHUNK_BYTES      = 4096
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic                          ap_start,
  output logic                          ap_done,
  output logic                          ap_idle,
  output logic                          ap_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_rd_addr_offset,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_wr_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  output logic                          rd_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  rd_xfer_size,
  input  logic                          rd_done,
  output logic                          wr_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  wr_xfer_size,
  input  logic                          wr_done,
  output logic [C_XFER_SIZE_WIDTH-1:0]  chunk_idx
`ifdef SYSARRAY_SCHED_PERF_EN
  ,
  output logic [31:0]                   perf_cycles
`endif
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int XW = C_XFER_SIZE_WIDTH;
  localparam logic [XW-1:0] CHUNK = XW'(C_CHUNK_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   rem_q, chunk_q, idx_q, rem_next;
  logic [AW-1:0]   rd_addr_q, wr_addr_q;
  logic            rd_seen_q, wr_seen_q, both_done;

  function automatic logic [XW-1:0] clip(input logic [XW-1:0] n);
    return (n > CHUNK) ? CHUNK : n;
  endfunction

  // The completing pulse counts in the same cycle it arrives.
  assign both_done = (rd_seen_q | rd_done) & (wr_seen_q | wr_done);
  assign rem_next  = rem_q - chunk_q;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ap_start) state_d = (ctrl_xfer_size_in_bytes == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (both_done) state_d = (rem_next == '0) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rem_q     <= '0;
      chunk_q   <= '0;
      idx_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            rem_q     <= ctrl_xfer_size_in_bytes;
            chunk_q   <= clip(ctrl_xfer_size_in_bytes);
            rd_addr_q <= ctrl_rd_addr_offset;
            wr_addr_q <= ctrl_wr_addr_offset;
            idx_q     <= '0;
          end
        end
        S_ISSUE: begin
          rd_seen_q <= 1'b0;
          wr_seen_q <= 1'b0;
        end
        S_WAIT: begin
          rd_seen_q <= rd_seen_q | rd_done;
          wr_seen_q <= wr_seen_q | wr_done;
          if (both_done) begin
            rem_q     <= rem_next;
            chunk_q   <= clip(rem_next);
            rd_addr_q <= rd_addr_q + AW'(chunk_q);
            wr_addr_q <= wr_addr_q + AW'(chunk_q);
            idx_q     <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SYSARRAY_SCHED_PERF_EN
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      perf_cycles <= '0;
    end else if (state_q == S_IDLE) begin
      if (ap_start) perf_cycles <= '0;
    end else if (perf_cycles != 32'hFFFF_FFFF) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

  assign ap_idle        = (state_q == S_IDLE);
  assign ap_done        = (state_q == S_DONE);
  assign ap_ready       = (state_q == S_DONE);
  assign rd_start       = (state_q == S_ISSUE);
  assign wr_start       = (state_q == S_ISSUE);
  assign rd_addr_offset = rd_addr_q;
  assign wr_addr_offset = wr_addr_q;
  assign rd_xfer_size   = chunk_q;
  assign wr_xfer_size   = chunk_q;
  assign chunk_idx      = idx_q;

endmodule

// File: tb/tb_sysarray_xfer_scheduler.sv
// Directed bench for sysarray_xfer_scheduler: chunking, done ordering, zero size, spurious inputs, wrap, reset.
module tb_sysarray_xfer_scheduler;

  logic        aclk;
  logic        areset_n;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [63:0] ctrl_rd_addr_offset, ctrl_wr_addr_offset;
  logic [31:0] ctrl_xfer_size_in_bytes;
  logic        rd_start, wr_start, rd_done, wr_done;
  logic [63:0] rd_addr_offset, wr_addr_offset;
  logic [31:0] rd_xfer_size, wr_xfer_size, chunk_idx;
`ifdef SYSARRAY_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sysarray_xfer_scheduler dut (
    .aclk                    (aclk),
    .areset_n                (areset_n),
    .ap_start                (ap_start),
    .ap_done                 (ap_done),
    .ap_idle                 (ap_idle),
    .ap_ready                (ap_ready),
    .ctrl_rd_addr_offset     (ctrl_rd_addr_offset),
    .ctrl_wr_addr_offset     (ctrl_wr_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .rd_start                (rd_start),
    .rd_addr_offset          (rd_addr_offset),
    .rd_xfer_size            (rd_xfer_size),
    .rd_done                 (rd_done),
    .wr_start                (wr_start),
    .wr_addr_offset          (wr_addr_offset),
    .wr_xfer_size            (wr_xfer_size),
    .wr_done                 (wr_done),
    .chunk_idx               (chunk_idx)
`ifdef SYSARRAY_SCHED_PERF_EN
    ,
    .perf_cycles             (perf_cycles)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_both();
    rd_done = 1'b1;
    wr_done = 1'b1;
    tick();
    rd_done = 1'b0;
    wr_done = 1'b0;
  endtask

  task automatic chk_issue(input string tag, input logic [63:0] ra, input logic [63:0] wa,
                           input logic [31:0] sz, input logic [31:0] idx);
    chk({tag, "_rd_start"}, 64'(rd_start), 64'd1);
    chk({tag, "_wr_start"}, 64'(wr_start), 64'd1);
    chk({tag, "_rd_addr"}, rd_addr_offset, ra);
    chk({tag, "_wr_addr"}, wr_addr_offset, wa);
    chk({tag, "_rd_size"}, 64'(rd_xfer_size), 64'(sz));
    chk({tag, "_wr_size"}, 64'(wr_xfer_size), 64'(sz));
    chk({tag, "_idx"}, 64'(chunk_idx), 64'(idx));
  endtask

  task automatic start_job(input logic [63:0] ra, input logic [63:0] wa, input logic [31:0] sz);
    ctrl_rd_addr_offset     = ra;
    ctrl_wr_addr_offset     = wa;
    ctrl_xfer_size_in_bytes = sz;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
  endtask

  initial begin
    areset_n = 1'b0;
    ap_start = 1'b0;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    ctrl_rd_addr_offset     = '0;
    ctrl_wr_addr_offset     = '0;
    ctrl_xfer_size_in_bytes = '0;
    #2;
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_done", 64'(ap_done), 64'd0);
    chk("rst_ready", 64'(ap_ready), 64'd0);
    chk("rst_rd_start", 64'(rd_start), 64'd0);
    chk("rst_wr_start", 64'(wr_start), 64'd0);
    chk("rst_rd_addr", rd_addr_offset, 64'd0);
    chk("rst_size", 64'(rd_xfer_size), 64'd0);
    chk("rst_idx", 64'(chunk_idx), 64'd0);
    tick();
    tick();
    areset_n = 1'b1;
    tick();

    // Size 10000 in 4096-byte chunks: 4096/4096/1808.
    start_job(64'h1000, 64'h8000, 32'd10000);
    chk("t1_idle_low", 64'(ap_idle), 64'd0);
    chk_issue("t1_c0", 64'h1000, 64'h8000, 32'd4096, 32'd0);
    tick();
    chk("t1_c0_wait_nostart", 64'(rd_start), 64'd0);
    pulse_both();
    chk_issue("t1_c1", 64'h2000, 64'h9000, 32'd4096, 32'd1);
    tick();
    pulse_both();
    chk_issue("t1_c2", 64'h3000, 64'hA000, 32'd1808, 32'd2);
    tick();
    pulse_both();
    chk("t1_done", 64'(ap_done), 64'd1);
    chk("t1_ready", 64'(ap_ready), 64'd1);
    chk("t1_done_idle", 64'(ap_idle), 64'd0);
    tick();
    chk("t1_done_end", 64'(ap_done), 64'd0);
    chk("t1_idle_back", 64'(ap_idle), 64'd1);
    chk("t1_no_extra", 64'(rd_start), 64'd0);

    // Size 8192: wr_done leads rd_done by 5 cycles, then simultaneous.
    start_job(64'h0, 64'h100000, 32'd8192);
    chk_issue("t2_c0", 64'h0, 64'h100000, 32'd4096, 32'd0);
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_start", 64'(rd_start), 64'd0);
      chk("t2_hold_addr", rd_addr_offset, 64'h0);
      tick();
    end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk_issue("t2_c1", 64'h1000, 64'h101000, 32'd4096, 32'd1);
    tick();
    pulse_both();
    chk("t2_done", 64'(ap_done), 64'd1);
    tick();
    chk("t2_idle", 64'(ap_idle), 64'd1);

    // Zero size: straight to DONE, no start pulses.
    start_job(64'h5000, 64'h6000, 32'd0);
    chk("t3_done", 64'(ap_done), 64'd1);
    chk("t3_ready", 64'(ap_ready), 64'd1);
    chk("t3_no_rd_start", 64'(rd_start), 64'd0);
    chk("t3_no_wr_start", 64'(wr_start), 64'd0);
    tick();
    chk("t3_idle", 64'(ap_idle), 64'd1);
    chk("t3_done_end", 64'(ap_done), 64'd0);

    // Spurious inputs: done in IDLE, ap_start toggles and control changes while busy, double rd_done.
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("t4_idle_rd_done", 64'(ap_idle), 64'd1);
    chk("t4_idle_no_start", 64'(rd_start), 64'd0);
    start_job(64'h40000, 64'h50000, 32'd4096);
    chk_issue("t4_c0", 64'h40000, 64'h50000, 32'd4096, 32'd0);
    ap_start = 1'b1;
    ctrl_rd_addr_offset     = 64'hDEAD_0000;
    ctrl_xfer_size_in_bytes = 32'd99999;
    tick();
    ap_start = 1'b0;
    rd_done  = 1'b1;
    tick();
    rd_done  = 1'b0;
    ap_start = 1'b1;
    tick();
    rd_done  = 1'b1;
    tick();
    rd_done  = 1'b0;
    ap_start = 1'b0;
    chk("t4_wait_no_start", 64'(rd_start), 64'd0);
    chk("t4_wait_addr", rd_addr_offset, 64'h40000);
    chk("t4_wait_idx", 64'(chunk_idx), 64'd0);
    chk("t4_wait_no_done", 64'(ap_done), 64'd0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("t4_done", 64'(ap_done), 64'd1);
    chk("t4_addr_adv", rd_addr_offset, 64'h41000);
    tick();
    chk("t4_idle", 64'(ap_idle), 64'd1);
    tick();
    chk("t4_no_extra", 64'(rd_start), 64'd0);

    // Read address wraps modulo 2^64; reset lands during WAIT of chunk 1.
    start_job(64'hFFFF_FFFF_FFFF_F000, 64'h0, 32'd8192);
    chk_issue("t5_c0", 64'hFFFF_FFFF_FFFF_F000, 64'h0, 32'd4096, 32'd0);
    tick();
    pulse_both();
    chk_issue("t5_c1", 64'h0, 64'h1000, 32'd4096, 32'd1);
    tick();
    #2;
    areset_n = 1'b0;
    #1;
    chk("t5_rst_idle", 64'(ap_idle), 64'd1);
    chk("t5_rst_done", 64'(ap_done), 64'd0);
    chk("t5_rst_start", 64'(rd_start), 64'd0);
    chk("t5_rst_wr_addr", wr_addr_offset, 64'h0);
    chk("t5_rst_size", 64'(wr_xfer_size), 64'd0);
    chk("t5_rst_idx", 64'(chunk_idx), 64'd0);
    tick();
    areset_n = 1'b1;
    pulse_both();
    chk("t5_post_idle", 64'(ap_idle), 64'd1);
    chk("t5_post_no_done", 64'(ap_done), 64'd0);
    start_job(64'h2000, 64'h3000, 32'd4096);
    chk_issue("t5_new", 64'h2000, 64'h3000, 32'd4096, 32'd0);
    tick();
    pulse_both();
    chk("t5_new_done", 64'(ap_done), 64'd1);
    tick();

`ifdef SYSARRAY_SCHED_PERF_EN
    // ISSUE 1 + WAIT 21 + DONE 1 cycles.
    start_job(64'h0, 64'h0, 32'd4096);
    chk("t6_issue", 64'(rd_start), 64'd1);
    for (int i = 0; i < 21; i++) tick();
    pulse_both();
    chk("t6_done", 64'(ap_done), 64'd1);
    tick();
    chk("t6_perf", 64'(perf_cycles), 64'd23);
    tick();
    tick();
    chk("t6_perf_hold", 64'(perf_cycles), 64'd23);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
